// File: rtl/watch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// watch_pkg : seven-segment patterns (g..a, active-low) and BCD digit type
// Rev 1.0
// ----------------------------------------------------------------------------
package watch_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Code used for digits that have never been loaded; decodes as dark.
  localparam bcd_t BCD_DARK = 4'hF;

  function automatic logic bcd_valid(input bcd_t code);
    return (code <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : BCD to active-low seven-segment pattern, with dark override
// Rev 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import watch_pkg::*;
(
  input  bcd_t       code_i,
  input  logic       dark_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    if (!dark_i) begin
      case (code_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_driver : multiplexed common-anode display driver with frame-aligned
//                   double buffering, blank/blink masks and anode dead time
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_driver
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD         = 50,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PC_W = $clog2(SCAN_DIV);
  localparam int DI_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0] PC_DEAD = PC_W'(DEAD);
  localparam logic [DI_W-1:0] DI_LAST = DI_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_buf_t;

  localparam disp_buf_t BUF_RESET = '{
    digits: {NUM_DIGITS{BCD_DARK}},
    dp:     '0,
    blank:  '0,
    blink:  '0
  };

  logic [PC_W-1:0]       pc_q, pc_d;
  logic [DI_W-1:0]       di_q, di_d;
  logic [FC_W-1:0]       fc_q, fc_d;
  logic                  blink_ph_q, blink_ph_d;
  logic                  pending_q, pending_d;
  disp_buf_t             shadow_q, shadow_d;
  disp_buf_t             active_q, active_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic w_pc_wrap;
  logic w_di_wrap;
  logic w_frame;
  logic w_fc_wrap;
  logic w_window;

  assign w_pc_wrap = (pc_q == PC_LAST);
  assign w_di_wrap = (di_q == DI_LAST);
  assign w_frame   = w_pc_wrap & w_di_wrap;
  assign w_fc_wrap = (fc_q == FC_LAST);
  assign w_window  = (pc_q >= PC_DEAD);

  always_comb begin
    pc_d       = w_pc_wrap ? '0 : pc_q + 1'b1;
    di_d       = di_q;
    fc_d       = fc_q;
    blink_ph_d = blink_ph_q;
    if (w_pc_wrap) begin
      di_d = w_di_wrap ? '0 : di_q + 1'b1;
    end
    if (w_frame) begin
      fc_d = w_fc_wrap ? '0 : fc_q + 1'b1;
      if (w_fc_wrap) begin
        blink_ph_d = ~blink_ph_q;
      end
    end
  end

  // A load on the boundary cycle lands in the shadow after the old shadow
  // has been promoted, so pending must stay set for the following frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (w_frame && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = '{digits: digits, dp: dp_mask, blank: blank_mask, blink: blink_mask};
      pending_d = 1'b1;
    end
  end

  bcd_t w_code;
  logic w_dp;
  logic w_blank;
  logic w_blink;
  logic w_dark;
  logic [6:0] w_seg_n;

  always_comb begin
    w_code  = BCD_DARK;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (di_q == DI_W'(k)) begin
        w_code  = active_q.digits[4*k +: 4];
        w_dp    = active_q.dp[k];
        w_blank = active_q.blank[k];
        w_blink = active_q.blink[k];
      end
    end
  end

  assign w_dark = w_blank | (w_blink & blink_ph_q) | ~bcd_valid(w_code);

  seg7_decode u_decode (
    .code_i  (w_code),
    .dark_i  (w_dark),
    .seg_n_o (w_seg_n)
  );

  // Dark digits still get their anode so every slot draws the same duty.
  always_comb begin
    seg_n_d      = w_seg_n;
    dp_n_d       = w_dark | ~w_dp;
    frame_done_d = w_frame;
    an_n_d       = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_n_d[k] = ~(w_window && (di_q == DI_W'(k)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      di_q         <= '0;
      fc_q         <= '0;
      blink_ph_q   <= 1'b0;
      pending_q    <= 1'b0;
      shadow_q     <= BUF_RESET;
      active_q     <= BUF_RESET;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      di_q         <= di_d;
      fc_q         <= fc_d;
      blink_ph_q   <= blink_ph_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// tb_seg_scan_driver: directed checks of scan timing, buffering, blink,
// blank/invalid/dp handling and mid-frame reset on a 6-digit, 4-cycle-slot build.
module tb_seg_scan_driver;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int DT = 1;
  localparam int BF = 2;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic [5:0]  blank_mask;
  logic [5:0]  blink_mask;
  logic        load;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        frame_done;

  int n = 0;
  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEAD         (DT),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // n = number of rising edges since reset was released
  always @(posedge clk) n <= rst ? 0 : n + 1;

  function automatic logic [5:0] exp_an(input int nn);
    int m;
    if (nn == 0) return 6'h3F;
    m = nn - 1;
    if ((m % SD) < DT) return 6'h3F;
    return ~(6'd1 << ((m % FR) / SD));
  endfunction

  task automatic goto_n(input int t);
    int guard;
    guard = 0;
    while (n != t && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto: n=%0d required %0d", n, t);
    end
  endtask

  task automatic load_mid(input logic [23:0] d, input logic [5:0] dp,
                          input logic [5:0] bl, input logic [5:0] bk,
                          output int boundary);
    int t;
    t = FR * (n / FR + 1) + 10;
    goto_n(t);
    digits = d; dp_mask = dp; blank_mask = bl; blink_mask = bk; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    boundary = FR * (t / FR + 1);
  endtask

  task automatic test_reset();
    logic [5:0] tbl [0:9];
    tbl[0] = 6'h3F; tbl[1] = 6'h3E; tbl[2] = 6'h3E; tbl[3] = 6'h3E; tbl[4] = 6'h3F;
    tbl[5] = 6'h3D; tbl[6] = 6'h3D; tbl[7] = 6'h3D; tbl[8] = 6'h3F; tbl[9] = 6'h3B;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== 6'h3F || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: seg_n=%h dp_n=%b an_n=%h fd=%b required 7f 1 3f 0",
               seg_n, dp_n, an_n, frame_done);
    end
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if (i <= 10 && an_n !== tbl[i-1]) begin
        n_bad++;
        $display("FAIL reset_an_seq: cycle %0d an_n=%h required %h", i, an_n, tbl[i-1]);
      end
      n_cmp++;
      if (an_n !== exp_an(n) || seg_n !== 7'h7F || dp_n !== 1'b1
          || frame_done !== ((n % FR) == 0)) begin
        n_bad++;
        $display("FAIL reset_scan: n=%0d an_n=%h seg_n=%h dp_n=%b fd=%b required %h 7f 1 %b",
                 n, an_n, seg_n, dp_n, frame_done, exp_an(n), ((n % FR) == 0));
      end
    end
  endtask

  task automatic test_load_decode();
    logic [6:0] es [0:5];
    int fb, d;
    es[0] = 7'h10; es[1] = 7'h12; es[2] = 7'h19;
    es[3] = 7'h30; es[4] = 7'h24; es[5] = 7'h79;
    load_mid(24'h123459, 6'h00, 6'h00, 6'h00, fb);
    while (n < fb) begin
      @(negedge clk);
      n_cmp++;
      if (seg_n !== 7'h7F) begin
        n_bad++;
        $display("FAIL load_same_frame: n=%0d seg_n=%h required 7f", n, seg_n);
      end
    end
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      d = ((n - 1) % FR) / SD;
      n_cmp++;
      if (seg_n !== es[d] || dp_n !== 1'b1 || an_n !== exp_an(n)) begin
        n_bad++;
        $display("FAIL load_decode: n=%0d digit %0d seg_n=%h dp_n=%b an_n=%h required %h 1 %h",
                 n, d, seg_n, dp_n, an_n, es[d], exp_an(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ea [0:5];
    logic [6:0] eb [0:5];
    int fb, d;
    ea[0] = 7'h40; ea[1] = 7'h12; ea[2] = 7'h02; ea[3] = 7'h78; ea[4] = 7'h00; ea[5] = 7'h10;
    eb[0] = 7'h12; eb[1] = 7'h19; eb[2] = 7'h30; eb[3] = 7'h24; eb[4] = 7'h79; eb[5] = 7'h40;
    load_mid(24'h987650, 6'h00, 6'h00, 6'h00, fb);
    goto_n(fb - 1);
    digits = 24'h012345; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (i != 0) @(negedge clk);
      d = ((n - 1) % FR) / SD;
      if (i == 0) continue;
      n_cmp++;
      if (seg_n !== ((i <= FR) ? ea[d] : eb[d])) begin
        n_bad++;
        $display("FAIL boundary_load: n=%0d digit %0d seg_n=%h required %h",
                 n, d, seg_n, (i <= FR) ? ea[d] : eb[d]);
      end
    end
    @(negedge clk);
    d = ((n - 1) % FR) / SD;
    n_cmp++;
    if (seg_n !== eb[d]) begin
      n_bad++;
      $display("FAIL boundary_load_end: n=%0d seg_n=%h required %h", n, seg_n, eb[d]);
    end
  endtask

  task automatic test_blink();
    logic [6:0] es [0:5];
    logic [6:0] want;
    int fb, d, f, dark_frames;
    logic ph;
    es[0] = 7'h10; es[1] = 7'h12; es[2] = 7'h19;
    es[3] = 7'h30; es[4] = 7'h24; es[5] = 7'h79;
    load_mid(24'h123459, 6'h00, 6'h00, 6'b000011, fb);
    goto_n(fb);
    dark_frames = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      d = ((n - 1) % FR) / SD;
      f = (n - 1) / FR;
      ph = ((f / BF) % 2) == 1;
      want = (ph && d < 2) ? 7'h7F : es[d];
      if (d == 0 && ((n - 1) % FR) == 2 && seg_n === 7'h7F) dark_frames++;
      n_cmp++;
      if (seg_n !== want || dp_n !== 1'b1) begin
        n_bad++;
        $display("FAIL blink: n=%0d frame %0d digit %0d seg_n=%h dp_n=%b required %h 1",
                 n, f, d, seg_n, dp_n, want);
      end
    end
    n_cmp++;
    if (dark_frames !== 2) begin
      n_bad++;
      $display("FAIL blink_duty: dark frames=%0d of 4 required 2", dark_frames);
    end
  endtask

  task automatic test_blank_dp();
    logic [6:0] es [0:5];
    logic       ed [0:5];
    int fb, d;
    es[0] = 7'h02; es[1] = 7'h7F; es[2] = 7'h19; es[3] = 7'h7F; es[4] = 7'h24; es[5] = 7'h79;
    ed[0] = 1'b1;  ed[1] = 1'b1;  ed[2] = 1'b0;  ed[3] = 1'b1;  ed[4] = 1'b1;  ed[5] = 1'b1;
    load_mid(24'h12A456, 6'b001110, 6'b000010, 6'h00, fb);
    goto_n(fb);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      d = ((n - 1) % FR) / SD;
      n_cmp++;
      if (seg_n !== es[d] || dp_n !== ed[d] || an_n !== exp_an(n)) begin
        n_bad++;
        $display("FAIL blank_dp: n=%0d digit %0d seg_n=%h dp_n=%b an_n=%h required %h %b %h",
                 n, d, seg_n, dp_n, an_n, es[d], ed[d], exp_an(n));
      end
    end
  endtask

  task automatic test_reset_mid();
    int fb;
    load_mid(24'h654321, 6'b001000, 6'h00, 6'h00, fb);
    goto_n(fb + 2);
    digits = 24'h888888; dp_mask = 6'h3F; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    goto_n(fb + 14);
    n_cmp++;
    if (seg_n !== 7'h19 || dp_n !== 1'b0 || an_n !== 6'h37) begin
      n_bad++;
      $display("FAIL pre_reset: seg_n=%h dp_n=%b an_n=%h required 19 0 37", seg_n, dp_n, an_n);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== 6'h3F || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: seg_n=%h dp_n=%b an_n=%h fd=%b required 7f 1 3f 0",
               seg_n, dp_n, an_n, frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * FR + 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== exp_an(n)
          || frame_done !== ((n % FR) == 0)) begin
        n_bad++;
        $display("FAIL pending_discard: n=%0d seg_n=%h dp_n=%b an_n=%h fd=%b required 7f 1 %h %b",
                 n, seg_n, dp_n, an_n, frame_done, exp_an(n), ((n % FR) == 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    digits = '0;
    dp_mask = '0;
    blank_mask = '0;
    blink_mask = '0;
    load = 1'b0;
    test_reset();
    test_load_decode();
    test_back_to_back();
    test_blink();
    test_blank_dp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed seven-segment display driver for the watch datapath. It consumes the packed BCD digits produced by the binary-to-BCD stage (hours, minutes and seconds, tens and ones each) and time-multiplexes them onto a common-anode display. It provides tear-free double buffering, per-digit blanking and blinking, and anti-ghosting dead time.

## Interface
- `NUM_DIGITS`, 6: number of display digits; digit 0 is rightmost.
- `SCAN_DIV`, 1000: clock cycles per digit slot; must be ≥ 2.
- `DEAD`, 50: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ DEAD < SCAN_DIV.
- `BLINK_FRAMES`, 100: number of frames per blink half-period; must be ≥ 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `digits` in 4*NUM_DIGITS: BCD codes; digit k occupies bits [4k+3:4k].
- `dp_mask` in NUM_DIGITS: decimal point on, per digit.
- `blank_mask` in NUM_DIGITS: force digit dark.
- `blink_mask` in NUM_DIGITS: digit is dark during blink phase 1.
- `load` in 1: single-cycle strobe; captures `digits` and all masks into the shadow buffer.
- `seg_n` out 7: segments g..a, active-low.
- `dp_n` out 1: decimal point, active-low.
- `an_n` out NUM_DIGITS: anodes, active-low, at most one low.
- `frame_done` out 1: one-cycle pulse when the digit index wraps to 0.

## Operation
- **Prescaler** `pc` counts 0..SCAN_DIV-1 and wraps. On wrap, digit index `di` advances 0..NUM_DIGITS-1 and wraps.
- **Frame boundary**: the cycle in which `pc` wraps and `di` goes from NUM_DIGITS-1 to 0. `frame_done` pulses in the following cycle.
- **Buffering**: `load` copies the inputs into the shadow registers and sets `pending`. At a frame boundary with `pending` set, the active registers take the shadow values and `pending` clears. The display never mixes old and new data within one frame.
- **Load at the boundary**: if `load` coincides with a frame boundary, the shadow takes the new data. The active registers take the previous shadow contents (if pending). `pending` stays set, so the new data applies at the next boundary.
- **Repeated loads**: multiple `load` pulses within one frame keep only the last value.
- **Blink**: frame counter `fc` counts 0..BLINK_FRAMES-1. On wrap, `blink_ph` toggles.
- **Digit dark condition**: digit k is dark when any of these holds:
  - `blank_mask[k]`,
  - `blink_mask[k]` and `blink_ph`=1,
  - BCD code > 9.
- **Dark digit output**: `seg_n`=7'h7F and `dp_n`=1. The anode is still driven, which keeps brightness uniform.
- **Segment decode** (active-low, g..a): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
- **Dead time**: during `pc` < DEAD, `an_n` is all ones.
- **Active window**: during DEAD ≤ `pc` < SCAN_DIV, `an_n[di]`=0.

## Timing
- **Reset values**: `seg_n`=7'h7F, `dp_n`=1, `an_n`=all ones, `frame_done`=0.
- **Reset values, internal state**: `pc`=0, `di`=0, `fc`=0, `blink_ph`=0, `pending`=0. Active and shadow digits = 4'hF (dark), all masks 0.
- **Output latency**: all outputs are registered. Each output reflects the (`pc`, `di`, active data) of the previous cycle, so latency is 1 cycle.
- **Load to visible**: data loaded mid-frame first appears in the slot of digit 0 of the next frame. The first visible output is DEAD+1 cycles after that boundary.
- **Reset mid-frame**: everything returns to reset values on the next edge, and any pending load is discarded.
- **Period**: one frame is NUM_DIGITS×SCAN_DIV cycles. One blink half-period is BLINK_FRAMES frames.

## Structure
- **Shared package** `watch_pkg`: the SEG_0..SEG_9 and SEG_BLANK constants, plus the BCD digit type.
- **Sub-module** `seg7_decode`: combinational; inputs are the 4-bit code and a dark flag, output is the 7-bit active-low segment pattern. It is instantiated once, on the muxed digit.
- **Top level**: prescaler, digit index, frame/blink counters, shadow/active registers, and output registers.

## Test plan
- **Reset, then scan**: NUM_DIGITS=6, SCAN_DIV=4, DEAD=1; release `rst`.
  - Required: `an_n` = 3F for 2 cycles, then 3E for 3 cycles, then 3F, then 3D, and so on.
  - Required: `frame_done` pulses every 24 cycles.
  - Required: `seg_n`=7F throughout, because the digits are dark from reset.
- **Load and decode**: `load` with digits = 0x123459 mid-frame.
  - Required: the current frame is unchanged.
  - Required: in the next frame, digit 0 shows `seg_n`=10, digit 5 shows 79, digit 2 shows 19.
- **Load coinciding with the boundary**: load A, then load B exactly at the frame boundary.
  - Required: the next frame shows A; the frame after shows B.
- **Blink**: BLINK_FRAMES=2, `blink_mask`=6'b000011.
  - Required: digits 0–1 are lit for 2 frames and dark for 2 frames.
  - Required: the other digits are always lit.
- **Blank, invalid code, dp**: code 4'hA on digit 3, `blank_mask[1]`=1, `dp_mask[2]`=1.
  - Required: digits 1 and 3 show `seg_n`=7F and `dp_n`=1.
  - Required: digit 2 has `dp_n`=0.
- **Reset mid-frame**: assert `rst` while `di`=3 with pending data.
  - Required: on the next edge, outputs return to reset values.
  - Required: the pending data is never displayed.
